// File: rtl/ltc_frame_align.sv
// ltc_frame_align
// ---------------------------------------------------------------------------
// Frame-lane word aligner for the LTC2175 deserialiser path (clkdiv domain).
// The controller watches the ISERDES frame word and pulses bitslip until the
// word matches FRAME_PATTERN. It then declares lock, watches for loss of lock
// and re-aligns on its own. The data-lane ISERDES share the bitslip output.
//
// Ports:
//   clkdiv      in   divided ADC clock; all logic runs on its rising edge
//   clk_reset   in   asynchronous, active-high reset
//   frame_word  in   [SER_WIDTH] deserialised frame-lane word
//   start       in   one-cycle request to (re)start alignment
//   bitslip     out  one-cycle pulse to the ISERDES BITSLIP inputs
//   aligned     out  high while locked
//   align_fail  out  high once MAX_SLIPS are used without lock (sticky)
//   slip_count  out  [$clog2(MAX_SLIPS+1)] slips issued in this attempt
//   loss_pulse  out  one-cycle pulse on loss of lock
//   err_count   out  [16] saturating count of mismatches seen while locked
//                    (present only when LTC_FRAME_ERR_CNT_EN is defined)
//
// Optional feature macro: LTC_FRAME_ERR_CNT_EN
// ---------------------------------------------------------------------------
module ltc_frame_align #(
    parameter int                   SER_WIDTH     = 8,
    parameter logic [SER_WIDTH-1:0] FRAME_PATTERN = 8'hF0,
    parameter int                   SETTLE_CYCLES = 4,
    parameter int                   MATCH_COUNT   = 16,
    parameter int                   LOSS_COUNT    = 4,
    parameter int                   MAX_SLIPS     = 16
) (
    input  logic                             clkdiv,
    input  logic                             clk_reset,
    input  logic [SER_WIDTH-1:0]             frame_word,
    input  logic                             start,
    output logic                             bitslip,
    output logic                             aligned,
    output logic                             align_fail,
    output logic [$clog2(MAX_SLIPS+1)-1:0]   slip_count,
`ifdef LTC_FRAME_ERR_CNT_EN
    output logic [15:0]                      err_count,
`endif
    output logic                             loss_pulse
);

    localparam int SCW = $clog2(MAX_SLIPS + 1);
    localparam int MCW = $clog2(MATCH_COUNT + 1);
    localparam int LCW = $clog2(LOSS_COUNT + 1);
    localparam int STW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [SCW-1:0] SLIP_MAX    = SCW'(MAX_SLIPS);
    localparam logic [MCW-1:0] MATCH_LAST  = MCW'(MATCH_COUNT - 1);
    localparam logic [LCW-1:0] LOSS_LAST   = LCW'(LOSS_COUNT - 1);
    localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SLIP,
        WAIT,
        LOCKED,
        FAIL
    } state_t;

    state_t         state, state_n;
    logic [MCW-1:0] match_cnt, match_n;
    logic [LCW-1:0] loss_cnt, loss_n;
    logic [STW-1:0] settle_cnt, settle_n;
    logic [SCW-1:0] slip_n;
    logic           loss_pulse_n;
    logic           word_ok;

    assign word_ok = (frame_word == FRAME_PATTERN);

    always_ff @(posedge clkdiv or posedge clk_reset) begin
        if (clk_reset) begin
            state      <= IDLE;
            match_cnt  <= '0;
            loss_cnt   <= '0;
            settle_cnt <= '0;
            slip_count <= '0;
            bitslip    <= 1'b0;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
            loss_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            match_cnt  <= match_n;
            loss_cnt   <= loss_n;
            settle_cnt <= settle_n;
            slip_count <= slip_n;
            // Outputs are registered copies of the next state, so each one
            // is valid for exactly the cycles spent in its state.
            bitslip    <= (state_n == SLIP);
            aligned    <= (state_n == LOCKED);
            align_fail <= (state_n == FAIL);
            loss_pulse <= loss_pulse_n;
        end
    end

    always_comb begin
        state_n      = state;
        match_n      = match_cnt;
        loss_n       = loss_cnt;
        settle_n     = settle_cnt;
        slip_n       = slip_count;
        loss_pulse_n = 1'b0;

        case (state)
            IDLE: ;
            CHECK: begin
                if (word_ok) begin
                    if (match_cnt == MATCH_LAST) begin
                        state_n = LOCKED;
                        match_n = '0;
                        loss_n  = '0;
                    end else begin
                        match_n = match_cnt + 1'b1;
                    end
                end else begin
                    match_n = '0;
                    state_n = (slip_count == SLIP_MAX) ? FAIL : SLIP;
                end
            end
            SLIP: begin
                if (slip_count != SLIP_MAX)
                    slip_n = slip_count + 1'b1;
                settle_n = '0;
                state_n  = WAIT;
            end
            WAIT: begin
                // Words arriving here predate the slip; ignore them.
                if (settle_cnt == SETTLE_LAST) begin
                    settle_n = '0;
                    state_n  = CHECK;
                end else begin
                    settle_n = settle_cnt + 1'b1;
                end
            end
            LOCKED: begin
                if (!word_ok) begin
                    if (loss_cnt == LOSS_LAST) begin
                        state_n      = CHECK;
                        loss_n       = '0;
                        match_n      = '0;
                        slip_n       = '0;
                        loss_pulse_n = 1'b1;
                    end else begin
                        loss_n = loss_cnt + 1'b1;
                    end
                end else begin
                    loss_n = '0;
                end
            end
            FAIL: ;
            default: state_n = IDLE;
        endcase

        // start wins over every other transition.
        if (start) begin
            state_n      = CHECK;
            match_n      = '0;
            loss_n       = '0;
            settle_n     = '0;
            slip_n       = '0;
            loss_pulse_n = 1'b0;
        end
    end

`ifdef LTC_FRAME_ERR_CNT_EN
    // Survives automatic re-align so software sees the full error history.
    always_ff @(posedge clkdiv or posedge clk_reset) begin
        if (clk_reset)
            err_count <= '0;
        else if (start)
            err_count <= '0;
        else if (state == LOCKED && !word_ok && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ltc_frame_align.sv
module tb_ltc_frame_align;

    localparam logic [7:0] PAT = 8'hF0;

    logic       clkdiv = 1'b0;
    logic       clk_reset = 1'b1;
    logic [7:0] frame_word;
    logic       start = 1'b0;
    logic       bitslip, aligned, align_fail, loss_pulse;
    logic [4:0] slip_count;
`ifdef LTC_FRAME_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    // ISERDES model state
    int   k = 0;
    int   slips = 0;
    logic bad = 1'b0;
    logic const_mode = 1'b0;
    int   cyc = 0;
    int   slip_times[$];
    int   lp_times[$];

    always #5 clkdiv = ~clkdiv;

    ltc_frame_align dut (
        .clkdiv     (clkdiv),
        .clk_reset  (clk_reset),
        .frame_word (frame_word),
        .start      (start),
        .bitslip    (bitslip),
        .aligned    (aligned),
        .align_fail (align_fail),
        .slip_count (slip_count),
`ifdef LTC_FRAME_ERR_CNT_EN
        .err_count  (err_count),
`endif
        .loss_pulse (loss_pulse)
    );

    function automatic logic [7:0] rotl(input logic [7:0] p, input int r);
        int rr;
        rr = r % 8;
        return (p << rr) | (p >> (8 - rr));
    endfunction

    always_comb begin
        frame_word = rotl(PAT, k + slips);
        if (const_mode)
            frame_word = 8'h00;
        else if (bad)
            frame_word = ~rotl(PAT, k + slips);
    end

    // One rotate per bitslip pulse, sampled mid-cycle.
    always @(negedge clkdiv) begin
        cyc = cyc + 1;
        if (bitslip) begin
            slips = slips + 1;
            slip_times.push_back(cyc);
        end
        if (loss_pulse)
            lp_times.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clkdiv);
            #1;
        end
    endtask

    // Make (k + slips) mod 8 equal to the requested rotation.
    task automatic set_off(input int t);
        k = (((t - slips) % 8) + 8) % 8;
    endtask

    // Pulse start; n counts edges from the one that samples start.
    task automatic pulse_start();
        @(negedge clkdiv);
        start = 1'b1;
        @(posedge clkdiv);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_aligned(input int bound, input string tag, output int n);
        n = 1;
        while (!aligned && n < bound) begin
            tick(1);
            n++;
        end
        if (!aligned) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_fail(input int bound);
        int n;
        n = 0;
        while (!align_fail && n < bound) begin
            tick(1);
            n++;
        end
        if (!align_fail) chk("fail_timeout", 0, 1);
    endtask

    // Returns right after the edge where the nth bitslip of this attempt shows.
    task automatic wait_slip(input int nth, input int bound);
        int seen, n;
        seen = 0;
        n = 0;
        while (seen < nth && n < bound) begin
            tick(1);
            n++;
            if (bitslip) seen++;
        end
        if (seen < nth) chk("slip_timeout", seen, nth);
    endtask

    function automatic int min_gap(input int base);
        int g;
        g = 1000000;
        for (int i = base + 1; i < slip_times.size(); i++)
            if (slip_times[i] - slip_times[i-1] < g) g = slip_times[i] - slip_times[i-1];
        return g;
    endfunction

    initial begin
        int n, base, lbase;

        // ---------------- reset state
        tick(3);
        chk("rst_bitslip", bitslip, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_fail", align_fail, 0);
        chk("rst_slipcnt", slip_count, 0);
        chk("rst_loss", loss_pulse, 0);
        @(negedge clkdiv);
        clk_reset = 1'b0;
        tick(2);

        // ---------------- k=0: lock with no slips, MATCH_COUNT+1 latency
        set_off(0);
        base = slip_times.size();
        pulse_start();
        wait_aligned(100, "k0", n);
        chk("k0_latency", n, 17);
        chk("k0_pulses", slip_times.size() - base, 0);
        chk("k0_slipcnt", slip_count, 0);

        // ---------------- k=3: five slips, spaced >= SETTLE+2
        set_off(3);
        base = slip_times.size();
        pulse_start();
        wait_aligned(300, "k3", n);
        chk("k3_aligned", aligned, 1);
        chk("k3_pulses", slip_times.size() - base, 5);
        chk("k3_gap_ok", min_gap(base) >= 6, 1);
        chk("k3_slipcnt", slip_count, 5);

        // ---------------- constant 00: exhaust MAX_SLIPS
        const_mode = 1'b1;
        base = slip_times.size();
        pulse_start();
        wait_fail(500);
        tick(10);
        chk("c0_fail", align_fail, 1);
        chk("c0_aligned", aligned, 0);
        chk("c0_slipcnt", slip_count, 16);
        chk("c0_pulses", slip_times.size() - base, 16);
        chk("c0_gap_ok", min_gap(base) >= 6, 1);
        const_mode = 1'b0;

        // ---------------- loss of lock and auto re-align
        set_off(0);
        pulse_start();
        chk("start_clr_fail", align_fail, 0);
        wait_aligned(100, "ll", n);
        lbase = lp_times.size();
        bad = 1'b1;
        tick(3);
        bad = 1'b0;
        tick(2);
        chk("ll3_aligned", aligned, 1);
        chk("ll3_nopulse", lp_times.size() - lbase, 0);
        bad = 1'b1;
        tick(3);
        chk("ll4_pre_aligned", aligned, 1);
        tick(1);
        bad = 1'b0;
        chk("ll4_pulse", loss_pulse, 1);
        chk("ll4_aligned", aligned, 0);
        chk("ll4_slipcnt", slip_count, 0);
        tick(1);
        chk("ll4_pulse_1cyc", loss_pulse, 0);
        wait_aligned(100, "relock", n);
        chk("relock_aligned", aligned, 1);
        chk("relock_slipcnt", slip_count, 0);
        chk("ll_pulses", lp_times.size() - lbase, 1);

        // ---------------- reset during WAIT after 2nd slip
        set_off(3);
        pulse_start();
        wait_slip(2, 200);
        tick(2);
        #2;
        clk_reset = 1'b1;
        #1;
        chk("mrst_bitslip", bitslip, 0);
        chk("mrst_aligned", aligned, 0);
        chk("mrst_fail", align_fail, 0);
        chk("mrst_slipcnt", slip_count, 0);
        chk("mrst_loss", loss_pulse, 0);
        @(negedge clkdiv);
        clk_reset = 1'b0;
        // model rotated twice already: offset 5 needs 3 more slips
        pulse_start();
        wait_aligned(300, "mrst", n);
        chk("mrst_relock_slipcnt", slip_count, 3);

        // ---------------- reset with bitslip in flight
        set_off(3);
        pulse_start();
        wait_slip(1, 100);
        chk("inflight_pre", bitslip, 1);
        #2;
        clk_reset = 1'b1;
        #1;
        chk("inflight_bitslip", bitslip, 0);
        @(negedge clkdiv);
        clk_reset = 1'b0;
        tick(2);

        // ---------------- start during SLIP
        set_off(3);
        pulse_start();
        wait_slip(2, 200);
        chk("mslip_cnt_pre", slip_count, 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("mslip_slipcnt", slip_count, 0);
        chk("mslip_bitslip", bitslip, 0);
        wait_aligned(300, "mslip", n);
        chk("mslip_relock_slipcnt", slip_count, 3);

`ifdef LTC_FRAME_ERR_CNT_EN
        // ---------------- error counter
        set_off(0);
        pulse_start();
        chk("err_clr", err_count, 0);
        wait_aligned(100, "err", n);
        bad = 1'b1; tick(1); bad = 1'b0; tick(2);
        bad = 1'b1; tick(1); bad = 1'b0; tick(2);
        chk("err_count", err_count, 2);
        chk("err_aligned", aligned, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
